burst_issuer: RTL and testbench

//  Converts a loaded count back into a stream of events: given LENGTH, BASE_ADDR and STRIDE,

---
 rtl/burst_issuer_pkg.sv | 18 +
 rtl/burst_issuer_if.sv | 32 +++
 rtl/burst_beat_counter.sv | 31 +++
 rtl/burst_issuer.sv | 97 +++++++++
 tb/tb_burst_issuer.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/burst_issuer_pkg.sv
// Shared definitions for the burst issuer.
// State encodings and default widths.
package burst_issuer_pkg;

    localparam int DEF_COUNT_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH  = 16;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ISSUE  = 2'd1;
    localparam logic [1:0] ST_FINISH = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE   = ST_IDLE,
        S_ISSUE  = ST_ISSUE,
        S_FINISH = ST_FINISH
    } state_t;

endpackage

// File: rtl/burst_issuer_if.sv
// Request beat bus: valid/ready handshake with
// address, index and last-beat marker.
interface burst_issuer_if
    import burst_issuer_pkg::*;
#(
    parameter int CW = DEF_COUNT_WIDTH,
    parameter int AW = DEF_ADDR_WIDTH
);

    logic          REQ_VALID;
    logic          REQ_READY;
    logic [AW-1:0] REQ_ADDR;
    logic [CW-1:0] REQ_INDEX;
    logic          REQ_LAST;

    modport master (
        output REQ_VALID,
        output REQ_ADDR,
        output REQ_INDEX,
        output REQ_LAST,
        input  REQ_READY
    );

    modport slave (
        input  REQ_VALID,
        input  REQ_ADDR,
        input  REQ_INDEX,
        input  REQ_LAST,
        output REQ_READY
    );

endinterface

// File: rtl/burst_beat_counter.sv
// Loadable beat index counter with a terminal flag
// raised when the index reaches the loaded limit.
module burst_beat_counter #(
    parameter int W = 8
) (
    input  logic         CLK,
    input  logic         RESET_N,
    input  logic         load,
    input  logic         inc,
    input  logic [W-1:0] limit,
    output logic [W-1:0] index,
    output logic         term
);

    logic [W-1:0] limit_q;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            index   <= '0;
            limit_q <= '0;
        end else if (load) begin
            index   <= '0;
            limit_q <= limit;
        end else if (inc) begin
            index   <= index + W'(1);
        end
    end

    assign term = (index == limit_q);

endmodule

// File: rtl/burst_issuer.sv
// Issues LENGTH strided request beats over a
// valid/ready bus and pulses DONE on completion.
module burst_issuer
    import burst_issuer_pkg::*;
#(
    parameter int COUNT_WIDTH = DEF_COUNT_WIDTH,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH
) (
    input  logic                   CLK,
    input  logic                   RESET_N,
    input  logic                   START,
    input  logic [COUNT_WIDTH-1:0] LENGTH,
    input  logic [ADDR_WIDTH-1:0]  BASE_ADDR,
    input  logic [ADDR_WIDTH-1:0]  STRIDE,
    input  logic                   ABORT,
    burst_issuer_if.master         req,
    output logic                   BUSY,
    output logic                   DONE
);

    state_t state_q;
    state_t state_d;

    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [ADDR_WIDTH-1:0]  stride_q;
    logic [COUNT_WIDTH-1:0] index;
    logic                   term;

    logic len_nz;
    logic load;
    logic fire;
    logic advance;

    assign len_nz  = (LENGTH != '0);
    assign load    = (state_q == S_IDLE) && START && len_nz;
    assign fire    = (state_q == S_ISSUE) && req.REQ_READY;
    assign advance = fire && !term;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (START) begin
                    state_d = len_nz ? S_ISSUE : S_FINISH;
                end
            end
            S_ISSUE: begin
                if ((fire && term) || ABORT) begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Address accumulates by stride; wraps at ADDR_WIDTH.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            addr_q   <= '0;
            stride_q <= '0;
        end else if (load) begin
            addr_q   <= BASE_ADDR;
            stride_q <= STRIDE;
        end else if (advance) begin
            addr_q   <= addr_q + stride_q;
        end
    end

    burst_beat_counter #(
        .W (COUNT_WIDTH)
    ) u_cnt (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .load    (load),
        .inc     (advance),
        .limit   (LENGTH - COUNT_WIDTH'(1)),
        .index   (index),
        .term    (term)
    );

    assign req.REQ_VALID = (state_q == S_ISSUE);
    assign req.REQ_LAST  = (state_q == S_ISSUE) && term;
    assign req.REQ_ADDR  = addr_q;
    assign req.REQ_INDEX = index;
    assign BUSY          = (state_q != S_IDLE);
    assign DONE          = (state_q == S_FINISH);

endmodule

// File: tb/tb_burst_issuer.sv
// Directed bench for burst_issuer: table of bursts
// plus stall, abort and async reset sequences.
module tb_burst_issuer;

    typedef struct packed {
        logic [7:0]       len;
        logic [15:0]      base;
        logic [15:0]      stride;
        int               exp_beats;
        logic [3:0][15:0] exp_addr;
    } vec_t;

    logic        CLK;
    logic        RESET_N;
    logic        START;
    logic [7:0]  LENGTH;
    logic [15:0] BASE_ADDR;
    logic [15:0] STRIDE;
    logic        ABORT;
    logic        BUSY;
    logic        DONE;

    int n_chk;
    int n_fail;

    vec_t vecs[6];

    burst_issuer_if #(.CW(8), .AW(16)) req_if ();

    burst_issuer #(
        .COUNT_WIDTH (8),
        .ADDR_WIDTH  (16)
    ) dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .START     (START),
        .LENGTH    (LENGTH),
        .BASE_ADDR (BASE_ADDR),
        .STRIDE    (STRIDE),
        .ABORT     (ABORT),
        .req       (req_if),
        .BUSY      (BUSY),
        .DONE      (DONE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h",
                     name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [7:0] len,
                                input logic [15:0] base,
                                input logic [15:0] stride,
                                input int nb,
                                input logic [15:0] a0,
                                input logic [15:0] a1,
                                input logic [15:0] a2,
                                input logic [15:0] a3);
        vec_t v;
        v.len         = len;
        v.base        = base;
        v.stride      = stride;
        v.exp_beats   = nb;
        v.exp_addr[0] = a0;
        v.exp_addr[1] = a1;
        v.exp_addr[2] = a2;
        v.exp_addr[3] = a3;
        return v;
    endfunction

    // stall_beat/abort_beat < 0 disables; poke pulses START mid-burst
    task automatic run_burst(input vec_t v,
                             input int stall_beat,
                             input int stall_n,
                             input int abort_beat,
                             input bit poke);
        int beats;
        int cyc;
        int last_cyc;
        int done_cyc;
        int first_v;
        int stall_left;
        logic [15:0] ea;
        beats      = 0;
        cyc        = 0;
        last_cyc   = -1;
        done_cyc   = -1;
        first_v    = -1;
        stall_left = stall_n;
        @(negedge CLK);
        START = 1'b1;
        LENGTH = v.len;
        BASE_ADDR = v.base;
        STRIDE = v.stride;
        ABORT = 1'b0;
        req_if.REQ_READY = 1'b1;
        while (cyc < 600) begin
            @(negedge CLK);
            cyc++;
            if (cyc == 1) begin
                START = 1'b0;
                LENGTH = 8'h5A;
                BASE_ADDR = 16'hDEAD;
                STRIDE = 16'h0BAD;
            end
            if (poke && cyc == 2) begin
                START = 1'b1;
                LENGTH = 8'd2;
            end
            if (poke && cyc == 3) START = 1'b0;
            if (done_cyc >= 0) begin
                chk("idle_busy", BUSY, 0);
                chk("done_width", DONE, 0);
                chk("idle_valid", req_if.REQ_VALID, 0);
                break;
            end
            chk("busy", BUSY, 1);
            if (DONE) begin
                chk("done_valid", req_if.REQ_VALID, 0);
                done_cyc = cyc;
            end
            if (req_if.REQ_VALID) begin
                if (first_v < 0) first_v = cyc;
                if (beats < 4) ea = v.exp_addr[beats];
                else ea = v.base + 16'(beats) * v.stride;
                chk("index", req_if.REQ_INDEX, beats);
                chk("addr", req_if.REQ_ADDR, ea);
                chk("last", req_if.REQ_LAST,
                    32'(beats == int'(v.len) - 1));
                if (beats == stall_beat && stall_left > 0) begin
                    req_if.REQ_READY = 1'b0;
                    stall_left--;
                end else begin
                    req_if.REQ_READY = 1'b1;
                end
                ABORT = (beats == abort_beat) && req_if.REQ_READY;
                if (req_if.REQ_READY) begin
                    beats++;
                    last_cyc = cyc;
                end
            end else begin
                req_if.REQ_READY = 1'b1;
                ABORT = 1'b0;
            end
        end
        if (done_cyc < 0) chk("timeout", 0, 1);
        chk("beats", beats, v.exp_beats);
        if (v.exp_beats > 0) begin
            chk("first_valid", first_v, 1);
            chk("done_lat", done_cyc, last_cyc + 1);
        end else begin
            chk("no_valid", first_v, 32'hFFFFFFFF);
            chk("done_lat0", done_cyc, 1);
        end
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        RESET_N = 1'b0;
        START = 1'b0;
        LENGTH = '0;
        BASE_ADDR = '0;
        STRIDE = '0;
        ABORT = 1'b0;
        req_if.REQ_READY = 1'b1;

        vecs[0] = mk(8'd4, 16'h0100, 16'h0004, 4,
                     16'h0100, 16'h0104, 16'h0108, 16'h010C);
        vecs[1] = mk(8'd3, 16'hFFF8, 16'h0008, 3,
                     16'hFFF8, 16'h0000, 16'h0008, 16'h0000);
        vecs[2] = mk(8'd1, 16'h1234, 16'h0010, 1,
                     16'h1234, 16'h0000, 16'h0000, 16'h0000);
        vecs[3] = mk(8'd2, 16'h0000, 16'hFFFF, 2,
                     16'h0000, 16'hFFFF, 16'h0000, 16'h0000);
        vecs[4] = mk(8'd0, 16'h0055, 16'h0001, 0,
                     16'h0000, 16'h0000, 16'h0000, 16'h0000);
        vecs[5] = mk(8'd255, 16'h0000, 16'h0001, 255,
                     16'h0000, 16'h0001, 16'h0002, 16'h0003);

        @(negedge CLK);
        @(negedge CLK);
        RESET_N = 1'b1;
        @(negedge CLK);
        chk("rst_valid", req_if.REQ_VALID, 0);
        chk("rst_last", req_if.REQ_LAST, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_done", DONE, 0);
        chk("rst_addr", req_if.REQ_ADDR, 0);
        chk("rst_index", req_if.REQ_INDEX, 0);

        for (int i = 0; i < 6; i++) begin
            run_burst(vecs[i], -1, 0, -1, 1'b0);
        end

        // beat 1 stalled two cycles, stray START mid-burst
        run_burst(mk(8'd3, 16'h0040, 16'h0020, 3,
                     16'h0040, 16'h0060, 16'h0080, 16'h0000),
                  1, 2, -1, 1'b1);

        // abort together with the handshake of beat 2
        run_burst(mk(8'd8, 16'h0200, 16'h0002, 3,
                     16'h0200, 16'h0202, 16'h0204, 16'h0000),
                  -1, 0, 2, 1'b0);

        // async reset between edges mid-burst
        @(negedge CLK);
        START = 1'b1;
        LENGTH = 8'd8;
        BASE_ADDR = 16'h0300;
        STRIDE = 16'h0001;
        req_if.REQ_READY = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        @(negedge CLK);
        chk("pre_rst_index", req_if.REQ_INDEX, 1);
        @(posedge CLK);
        #2 RESET_N = 1'b0;
        #1;
        chk("arst_valid", req_if.REQ_VALID, 0);
        chk("arst_last", req_if.REQ_LAST, 0);
        chk("arst_busy", BUSY, 0);
        chk("arst_done", DONE, 0);
        chk("arst_addr", req_if.REQ_ADDR, 0);
        chk("arst_index", req_if.REQ_INDEX, 0);
        @(negedge CLK);
        RESET_N = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            chk("post_rst_done", DONE, 0);
            chk("post_rst_valid", req_if.REQ_VALID, 0);
        end
        run_burst(mk(8'd2, 16'h0010, 16'h0010, 2,
                     16'h0010, 16'h0020, 16'h0000, 16'h0000),
                  -1, 0, -1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
